// File: rtl/out_channel_checker.sv
// out_channel_checker
// Far end of the program out channel. Words emitted by `out` instructions
// arrive over a valid/ready stream. They are buffered in a small FIFO and
// compared in order against a static expected table. The checker drives
// finished/success/timeout for the FPGA test top.
//
// Optional feature (macro OUT_CHECKER_OVERFLOW_EN):
//   When the macro is defined, the checker keeps accepting words after the run
//   is complete. Every extra word is drained and counted, and it turns the run
//   into a failure.
//
// Ports:
//   clock           driving clock
//   reset           synchronous, active-high reset
//   out_valid       producer has a word on out_data
//   out_data        word emitted by an `out` instruction
//   out_ready       checker can accept a word this cycle (registered)
//   expected        expected words; word i at bits [i*W +: W]; static during a run
//   finished        run is complete (pass, fail or timeout)
//   success         meaningful when finished=1; 1 only if all NOut words matched
//   received        number of words compared so far
//   mismatch_index  index of the first mismatching word; 8'hFF if none
//   timeout         StepLimit reached before NOut words were compared
module out_channel_checker #(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned NOut               = 12,
    parameter int unsigned FifoDepth          = 4,
    parameter int unsigned StepLimit          = 30
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               out_valid,
    input  logic [MemoryElementWidth-1:0]      out_data,
    output logic                               out_ready,
    input  logic [NOut*MemoryElementWidth-1:0] expected,
    output logic                               finished,
    output logic                               success,
    output logic [7:0]                         received,
    output logic [7:0]                         mismatch_index,
    output logic                               timeout
);

    localparam int unsigned W     = MemoryElementWidth;
    localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned StepW = $clog2(StepLimit + 2);

    localparam logic [7:0]       NoMismatch = 8'hFF;
    localparam logic [7:0]       NOutIdx    = 8'(NOut);
    localparam logic [CntW-1:0]  FullCount  = CntW'(FifoDepth);
    localparam logic [StepW-1:0] StepMax    = {StepW{1'b1}};
    localparam logic [StepW-1:0] StepLast   = StepW'(StepLimit);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [W-1:0]          fifo_q [FifoDepth];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic [StepW-1:0]      step_q;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                state_d;
    logic [PtrW-1:0]       wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_d;
    logic [CntW-1:0]       count_d;
    logic [StepW-1:0]      step_d;
    logic                  out_ready_d;
    logic                  finished_d;
    logic                  success_d;
    logic [7:0]            received_d;
    logic [7:0]            mismatch_index_d;
    logic                  timeout_d;

    logic                  push;
    logic                  pop;
    logic [W-1:0]          pop_word;
    logic [W-1:0]          exp_word;

    // Transfer handshake and head-of-FIFO word
    always_comb begin
        push     = out_valid && out_ready;
        pop_word = fifo_q[rd_ptr_q];
        exp_word = expected[32'(received) * W +: W];
`ifdef OUT_CHECKER_OVERFLOW_EN
        // Words are drained in DONE too, so that extras can be counted
        pop      = (count_q != '0);
`else
        pop      = (state_q == RUN) && (count_q != '0);
`endif
    end

    // Next-state and output logic
    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        step_d           = step_q;
        out_ready_d      = 1'b0;
        finished_d       = finished;
        success_d        = success;
        received_d       = received;
        mismatch_index_d = mismatch_index;
        timeout_d        = timeout;

        // FIFO pointer and occupancy bookkeeping
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            RUN: begin
                if (step_q != StepMax) begin
                    step_d = step_q + StepW'(1);
                end

                // Compare the popped word against the next expected entry
                if (pop) begin
                    if ((pop_word != exp_word) && (mismatch_index == NoMismatch)) begin
                        mismatch_index_d = received;
                    end
                    received_d = received + 8'd1;
                end

                // Completion takes priority over a simultaneous timeout
                if (received_d == NOutIdx) begin
                    state_d    = DONE;
                    finished_d = 1'b1;
                    success_d  = (mismatch_index_d == NoMismatch);
                    timeout_d  = 1'b0;
                end else if (step_q >= StepLast) begin
                    // The step count after this edge exceeds StepLimit
                    state_d    = DONE;
                    finished_d = 1'b1;
                    success_d  = 1'b0;
                    timeout_d  = 1'b1;
                end
            end

            DONE: begin
`ifdef OUT_CHECKER_OVERFLOW_EN
                // Any word drained after completion is an unexpected extra
                if (pop) begin
                    success_d = 1'b0;
                    if (mismatch_index == NoMismatch) begin
                        mismatch_index_d = NOutIdx;
                    end
                    if (received != 8'hFF) begin
                        received_d = received + 8'd1;
                    end
                end
`endif
            end

            default: begin
                state_d = RUN;
            end
        endcase

        // Ready reflects the occupancy at the end of this cycle
`ifdef OUT_CHECKER_OVERFLOW_EN
        out_ready_d = (count_d != FullCount);
`else
        out_ready_d = (state_d == RUN) && (count_d != FullCount);
`endif
    end

    // Control and status registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= RUN;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            step_q         <= '0;
            out_ready      <= 1'b0;
            finished       <= 1'b0;
            success        <= 1'b0;
            received       <= 8'd0;
            mismatch_index <= NoMismatch;
            timeout        <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            step_q         <= step_d;
            out_ready      <= out_ready_d;
            finished       <= finished_d;
            success        <= success_d;
            received       <= received_d;
            mismatch_index <= mismatch_index_d;
            timeout        <= timeout_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            fifo_q[wr_ptr_q] <= out_data;
        end
    end

endmodule

// File: tb/tb_out_channel_checker.sv
// Testbench for out_channel_checker: directed and randomized runs checked
// against a simple in-order reference model of the expected table.
module tb_out_channel_checker;

    localparam int unsigned W  = 12;
    localparam int unsigned N  = 12;
    localparam int unsigned SL = 30;

    logic             clock;
    logic             reset;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
    logic [N*W-1:0]   expected;
    logic             finished;
    logic             success;
    logic [7:0]       received;
    logic [7:0]       mismatch_index;
    logic             timeout;

    int n_checks;
    int n_fail;
    int cyc;

    logic [W-1:0] tbl [N];
    logic [W-1:0] sent [$];

    out_channel_checker #(
        .MemoryElementWidth(W),
        .NOut(N),
        .FifoDepth(4),
        .StepLimit(SL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .expected(expected),
        .finished(finished),
        .success(success),
        .received(received),
        .mismatch_index(mismatch_index),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycles since reset release
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic load_default_table();
        logic [W-1:0] d [N];
        d = '{3, 2, 1, 0, 3, 2, 1, 0, 0, 1, 2, 3};
        for (int i = 0; i < int'(N); i++) begin
            tbl[i] = d[i];
            expected[i*W +: W] = d[i];
        end
    endtask

    task automatic load_random_table();
        for (int i = 0; i < int'(N); i++) begin
            tbl[i] = W'($urandom_range(0, 4095));
            expected[i*W +: W] = tbl[i];
        end
    endtask

    // Model: index of the first word that differs from the table, or FF
    function automatic logic [7:0] model_first_mismatch();
        for (int i = 0; i < sent.size() && i < int'(N); i++) begin
            if (sent[i] !== tbl[i]) return 8'(i);
        end
        return 8'hFF;
    endfunction

    // Assert reset for two edges; leaves the bench at the negedge before edge 1
    task automatic apply_reset();
        @(negedge clock);
        reset     = 1'b1;
        out_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sent.delete();
    endtask

    // Offer one word; called at a negedge and returns at a negedge, valid held
    task automatic send(input logic [W-1:0] d, input int budget, output bit ok);
        bit rdy;
        ok        = 1'b0;
        out_valid = 1'b1;
        out_data  = d;
        for (int i = 0; i < budget; i++) begin
            rdy = out_ready;
            @(posedge clock);
            @(negedge clock);
            if (rdy) begin
                ok = 1'b1;
                sent.push_back(d);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        out_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_finished(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (finished === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        load_default_table();
        @(negedge clock);
        reset     = 1'b1;
        out_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({out_ready, finished, success, timeout} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/fin/suc/to=%b required 0000",
                     {out_ready, finished, success, timeout});
        end
        n_checks++;
        if (received !== 8'd0 || mismatch_index !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_counts: got received=%0d mismatch=%h required 0/FF",
                     received, mismatch_index);
        end
        reset = 1'b0;
        sent.delete();
    endtask

    task automatic run_sequence(input bit corrupt5, input string tag);
        bit ok;
        for (int i = 0; i < int'(N); i++) begin
            send((corrupt5 && i == 5) ? W'(7) : tbl[i], 10, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s_accept: word %0d not accepted, required accepted", tag, i);
            end
        end
        idle(0);
        wait_finished(SL + 5, ok);
        n_checks++;
        if (!ok || cyc > int'(SL)) begin
            n_fail++;
            $display("FAIL %s_finish: finished=%b at cycle %0d, required 1 within %0d",
                     tag, finished, cyc, SL);
        end
    endtask

    task automatic check_final(input string tag, input bit exp_to, input logic [7:0] exp_rx);
        logic [7:0] exp_mm;
        bit         exp_suc;
        exp_mm  = exp_to ? model_first_mismatch() : model_first_mismatch();
        exp_suc = !exp_to && (exp_mm == 8'hFF) && (exp_rx == 8'(N));
        n_checks++;
        if (success !== exp_suc || timeout !== exp_to || finished !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_flags: got fin/suc/to=%b%b%b required 1%b%b",
                     tag, finished, success, timeout, exp_suc, exp_to);
        end
        n_checks++;
        if (received !== exp_rx || mismatch_index !== exp_mm) begin
            n_fail++;
            $display("FAIL %s_counts: got received=%0d mismatch=%h required %0d/%h",
                     tag, received, mismatch_index, exp_rx, exp_mm);
        end
    endtask

    task automatic test_pass();
        load_default_table();
        apply_reset();
        run_sequence(1'b0, "pass");
        check_final("pass", 1'b0, 8'(N));
    endtask

    task automatic test_mismatch();
        load_default_table();
        apply_reset();
        run_sequence(1'b1, "mm");
        check_final("mm", 1'b0, 8'(N));
        n_checks++;
        if (mismatch_index !== 8'd5) begin
            n_fail++;
            $display("FAIL mm_index: got %0d required 5", mismatch_index);
        end
    endtask

    // Sustained valid: no word may be lost or duplicated
    task automatic test_back_to_back();
        bit ok;
        load_default_table();
        apply_reset();
        for (int i = 0; i < 6; i++) send(tbl[i], 10, ok);
        idle(3);
        n_checks++;
        if (received !== 8'd6 || mismatch_index !== 8'hFF || finished !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_mid: got received=%0d mismatch=%h fin=%b required 6/FF/0",
                     received, mismatch_index, finished);
        end
        for (int i = 6; i < int'(N); i++) send(tbl[i], 10, ok);
        idle(0);
        wait_finished(SL, ok);
        check_final("burst", 1'b0, 8'(N));
    endtask

    // Five words then silence: timeout exactly on cycle 31
    task automatic test_timeout();
        int  idx;
        bit  rdy;
        load_default_table();
        apply_reset();
        idx = 0;
        for (int k = 1; k <= 35; k++) begin
            out_valid = (idx < 5);
            out_data  = tbl[idx % int'(N)];
            rdy       = out_ready;
            @(posedge clock);
            if (out_valid && rdy) begin
                sent.push_back(tbl[idx]);
                idx++;
            end
            @(negedge clock);
            if (k == int'(SL)) begin
                n_checks++;
                if (finished !== 1'b0) begin
                    n_fail++;
                    $display("FAIL to_early: finished=%b at cycle %0d required 0", finished, k);
                end
            end
            if (k == int'(SL) + 1) begin
                n_checks++;
                if (finished !== 1'b1 || timeout !== 1'b1) begin
                    n_fail++;
                    $display("FAIL to_edge: fin/to=%b%b at cycle %0d required 11",
                             finished, timeout, k);
                end
            end
        end
        out_valid = 1'b0;
        check_final("to", 1'b1, 8'd5);
    endtask

    task automatic test_reset_midrun();
        bit ok;
        load_default_table();
        apply_reset();
        for (int i = 0; i < 6; i++) send(tbl[i], 10, ok);
        idle(1);
        test_reset();
        run_sequence(1'b0, "rerun");
        check_final("rerun", 1'b0, 8'(N));
    endtask

    // Random tables, random corruptions and random valid gaps
    task automatic test_random();
        bit         ok;
        logic [W-1:0] w;
        for (int it = 0; it < 5; it++) begin
            load_random_table();
            apply_reset();
            for (int i = 0; i < int'(N); i++) begin
                w = tbl[i];
                if ($urandom_range(0, 3) == 0) w = w ^ W'($urandom_range(1, 4095));
                if ($urandom_range(0, 1) == 1) idle(1);
                send(w, 10, ok);
            end
            idle(0);
            wait_finished(SL + 5, ok);
            check_final("rand", 1'b0, 8'(N));
        end
    endtask

    // A 13th word after completion
    task automatic test_extra_word();
        bit ok;
        load_default_table();
        apply_reset();
        run_sequence(1'b0, "extra");
        idle(2);
        send(W'(5), 4, ok);
        idle(3);
`ifdef OUT_CHECKER_OVERFLOW_EN
        n_checks++;
        if (!ok || success !== 1'b0 || mismatch_index !== 8'(N) || received !== 8'(N + 1)
            || finished !== 1'b1) begin
            n_fail++;
            $display("FAIL extra_ovf: acc=%b suc=%b mm=%0d rx=%0d fin=%b required 1/0/%0d/%0d/1",
                     ok, success, mismatch_index, received, finished, N, N + 1);
        end
`else
        n_checks++;
        if (ok || success !== 1'b1 || mismatch_index !== 8'hFF || received !== 8'(N)
            || finished !== 1'b1) begin
            n_fail++;
            $display("FAIL extra_block: acc=%b suc=%b mm=%h rx=%0d fin=%b required 0/1/FF/%0d/1",
                     ok, success, mismatch_index, received, finished, N);
        end
`endif
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        expected  = '0;
        test_reset();
        test_pass();
        test_mismatch();
        test_back_to_back();
        test_timeout();
        test_reset_midrun();
        test_random();
        test_extra_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
